// File: rtl/regbank_scheduler_if.sv
// regbank_scheduler_if
//   Bundles the issue, writeback and register-bank write signals around the
//   scheduler.
//   Issue side     : issue_valid, issue_rs/rt/rd, issue_stall (back)
//   Writeback side : {alu,mem}_valid/_addr/_data, {alu,mem}_ready (back)
//   Bank side      : enc, addrc, datac, plus busy_vec and sb_error status
//   modport slave  : the scheduler itself
//   modport master : the surrounding pipeline (decode, writeback, bank)
interface regbank_scheduler_if #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  logic             issue_valid;
  logic [AW-1:0]    issue_rs;
  logic [AW-1:0]    issue_rt;
  logic [AW-1:0]    issue_rd;
  logic             issue_stall;

  logic             alu_valid;
  logic [AW-1:0]    alu_addr;
  logic [DW-1:0]    alu_data;
  logic             alu_ready;

  logic             mem_valid;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_data;
  logic             mem_ready;

  logic             enc;
  logic [AW-1:0]    addrc;
  logic [DW-1:0]    datac;
  logic [NREGS-1:0] busy_vec;
  logic             sb_error;

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd,
    output issue_stall,
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output enc, addrc, datac, busy_vec, sb_error
  );

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd,
    input  issue_stall,
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  enc, addrc, datac, busy_vec, sb_error
  );
endinterface

// File: rtl/regbank_scheduler.sv
// regbank_scheduler
//   Shares the register bank's single write port between the ALU and memory
//   writeback paths (round-robin on contention) and keeps a per-register
//   busy scoreboard that stalls issue on RAW/WAW hazards.
//   clock : sole clock, all state updates on posedge
//   reset : asynchronous, active-low, clears all state
//   rb    : regbank_scheduler_if.slave
//           issue_*  -> issue_stall (combinational)
//           alu_*/mem_* writeback requests -> *_ready (combinational grant)
//           enc/addrc/datac : registered bank write port
//           busy_vec        : scoreboard (bit 0 always 0)
//           sb_error        : sticky, writeback to a non-busy register
module regbank_scheduler #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  regbank_scheduler_if.slave   rb
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // State
  src_e             rr_reg, rr_next;
  logic [NREGS-1:0] busy_reg, busy_next;
  logic             enc_reg, enc_next;
  logic [AW-1:0]    addrc_reg, addrc_next;
  logic [DW-1:0]    datac_reg, datac_next;
  logic             sb_error_reg, sb_error_next;

  // Combinational helpers
  logic             alu_gnt;
  logic             mem_gnt;
  logic             wb_fire;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             issue_stall;
  logic             issue_fire;

  // Hazard check reads the registered scoreboard only; a clear happening at
  // this edge is not visible until next cycle. busy_reg[0] is constant 0,
  // so rd = 0 never stalls.
  assign issue_stall = rb.issue_valid &&
                       (busy_reg[rb.issue_rs] | busy_reg[rb.issue_rt] |
                        busy_reg[rb.issue_rd]);
  assign issue_fire  = rb.issue_valid && !issue_stall;

  // Arbiter and round-robin pointer. The pointer only moves after a
  // contended grant, and then points at the source that just lost.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    rr_next = rr_reg;
    if (rb.alu_valid && rb.mem_valid) begin
      if (rr_reg == SRC_ALU) begin
        alu_gnt = 1'b1;
        rr_next = SRC_MEM;
      end else begin
        mem_gnt = 1'b1;
        rr_next = SRC_ALU;
      end
    end else begin
      alu_gnt = rb.alu_valid;
      mem_gnt = rb.mem_valid;
    end
  end

  assign wb_fire = alu_gnt | mem_gnt;
  assign wb_addr = mem_gnt ? rb.mem_addr : rb.alu_addr;
  assign wb_data = mem_gnt ? rb.mem_data : rb.alu_data;

  // Write stage. A handshake to r0 is consumed but never raises enc.
  // The error check uses the busy state seen at handshake time.
  always_comb begin
    enc_next      = 1'b0;
    addrc_next    = addrc_reg;
    datac_next    = datac_reg;
    sb_error_next = sb_error_reg;
    if (wb_fire) begin
      enc_next   = (wb_addr != '0);
      addrc_next = wb_addr;
      datac_next = wb_data;
      if ((wb_addr != '0) && !busy_reg[wb_addr]) begin
        sb_error_next = 1'b1;
      end
    end
  end

  // Scoreboard next state, one bit per register. The clear follows the
  // bank write (enc sampled at this edge). If a set and a clear ever meet
  // on one bit (only after an erroneous writeback), the new producer wins.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      assign busy_next[gi] =
        (issue_fire && (rb.issue_rd == AW'(gi))) ? 1'b1 :
        (enc_reg && (addrc_reg == AW'(gi)))      ? 1'b0 :
                                                   busy_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_reg       <= SRC_ALU;
      busy_reg     <= '0;
      enc_reg      <= 1'b0;
      addrc_reg    <= '0;
      datac_reg    <= '0;
      sb_error_reg <= 1'b0;
    end else begin
      rr_reg       <= rr_next;
      busy_reg     <= busy_next;
      enc_reg      <= enc_next;
      addrc_reg    <= addrc_next;
      datac_reg    <= datac_next;
      sb_error_reg <= sb_error_next;
    end
  end

  assign rb.issue_stall = issue_stall;
  assign rb.alu_ready   = alu_gnt;
  assign rb.mem_ready   = mem_gnt;
  assign rb.enc         = enc_reg;
  assign rb.addrc       = addrc_reg;
  assign rb.datac       = datac_reg;
  assign rb.busy_vec    = busy_reg;
  assign rb.sb_error    = sb_error_reg;

endmodule

// File: tb/tb_regbank_scheduler.sv
// tb_regbank_scheduler
//   Directed scenarios followed by constrained-random traffic, all checked
//   against a cycle-level reference model of the scoreboard/arbiter rules.
module tb_regbank_scheduler;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  regbank_scheduler_if #(.NREGS(NREGS), .AW(AW), .DW(DW)) rb ();

  regbank_scheduler #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .rb    (rb)
  );

  // Register bank stand-in written from the DUT's write port.
  logic [DW-1:0] bank_mem [NREGS];
  always @(posedge clock) begin
    if (rb.enc) bank_mem[rb.addrc] <= rb.datac;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [NREGS-1:0] busy_m;
  bit               alu_turn_m;   // ALU wins the next contention
  logic             pend_en_m;
  logic [AW-1:0]    pend_addr_m;
  logic [DW-1:0]    pend_data_m;
  logic             err_m;

  // Per-cycle observations for directed checks
  logic obs_stall, obs_alu_rdy, obs_mem_rdy;
  bit   alu_gnt_q, mem_gnt_q;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy_m      = '0;
    alu_turn_m  = 1'b1;
    pend_en_m   = 1'b0;
    pend_addr_m = '0;
    pend_data_m = '0;
    err_m       = 1'b0;
  endtask

  task automatic set_idle();
    rb.issue_valid = 1'b0;
    rb.issue_rs    = '0;
    rb.issue_rt    = '0;
    rb.issue_rd    = '0;
    rb.alu_valid   = 1'b0;
    rb.alu_addr    = '0;
    rb.alu_data    = '0;
    rb.mem_valid   = 1'b0;
    rb.mem_addr    = '0;
    rb.mem_data    = '0;
  endtask

  task automatic set_issue(input logic v, input int rs, input int rt, input int rd);
    rb.issue_valid = v;
    rb.issue_rs    = AW'(rs);
    rb.issue_rt    = AW'(rt);
    rb.issue_rd    = AW'(rd);
  endtask

  task automatic set_alu(input logic v, input int a, input logic [DW-1:0] d);
    rb.alu_valid = v;
    rb.alu_addr  = AW'(a);
    rb.alu_data  = d;
  endtask

  task automatic set_mem(input logic v, input int a, input logic [DW-1:0] d);
    rb.mem_valid = v;
    rb.mem_addr  = AW'(a);
    rb.mem_data  = d;
  endtask

  task automatic check_regs(input string pfx);
    check_eq({pfx, "_enc"},      rb.enc,      pend_en_m);
    check_eq({pfx, "_addrc"},    rb.addrc,    pend_addr_m);
    check_eq({pfx, "_datac"},    rb.datac,    pend_data_m);
    check_eq({pfx, "_busy_vec"}, rb.busy_vec, busy_m);
    check_eq({pfx, "_sb_error"}, rb.sb_error, err_m);
  endtask

  // One clock cycle. Called just after a posedge with inputs already set;
  // returns 1 time unit after the following posedge.
  task automatic cycle();
    logic             stall_e, aw, mw, fire;
    logic [NREGS-1:0] busy_n;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;
    @(negedge clock);
    stall_e = rb.issue_valid &&
              (busy_m[rb.issue_rs] || busy_m[rb.issue_rt] || busy_m[rb.issue_rd]);
    aw = rb.alu_valid && (!rb.mem_valid || alu_turn_m);
    mw = rb.mem_valid && !aw;
    obs_stall   = rb.issue_stall;
    obs_alu_rdy = rb.alu_ready;
    obs_mem_rdy = rb.mem_ready;
    check_eq("issue_stall", rb.issue_stall, stall_e);
    check_eq("alu_ready",   rb.alu_ready,   aw);
    check_eq("mem_ready",   rb.mem_ready,   mw);
    alu_gnt_q = aw;
    mem_gnt_q = mw;
    fire = rb.issue_valid && !stall_e;

    busy_n = busy_m;
    if (pend_en_m) busy_n[pend_addr_m] = 1'b0;
    if (fire && rb.issue_rd != 0) busy_n[rb.issue_rd] = 1'b1;

    if (aw || mw) begin
      a = aw ? rb.alu_addr : rb.mem_addr;
      d = aw ? rb.alu_data : rb.mem_data;
      $display("wb %s addr=%0d data=0x%08h", aw ? "ALU" : "MEM", a, d);
      if (a != 0 && !busy_m[a]) err_m = 1'b1;
      pend_en_m   = (a != 0);
      pend_addr_m = a;
      pend_data_m = d;
    end else begin
      pend_en_m = 1'b0;
    end
    if (rb.alu_valid && rb.mem_valid) alu_turn_m = mw;
    busy_m = busy_n;

    @(posedge clock);
    #1;
    check_regs("reg");
  endtask

  function automatic int find_busy();
    int start;
    start = $urandom_range(0, 7);
    for (int i = 0; i < 8; i++) begin
      if (busy_m[(start + i) % 8]) return (start + i) % 8;
    end
    return -1;
  endfunction

  task automatic new_req(output logic v, output int a);
    int pick;
    v = 1'b0;
    a = 0;
    if ($urandom_range(0, 99) < 60) begin
      pick = find_busy();
      if (pick > 0) begin
        v = 1'b1;
        a = pick;
      end else if ($urandom_range(0, 99) < 10) begin
        v = 1'b1;
        a = $urandom_range(0, 7);
      end
    end
  endtask

  initial begin
    logic v;
    int   a;

    set_idle();
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clock);
    #1;
    check_regs("por");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // RAW stall
    set_issue(1, 0, 0, 5);
    cycle();
    check_eq("raw_prod_accept", obs_stall, 0);
    set_issue(1, 5, 0, 0);
    cycle();
    check_eq("raw_stall_0", obs_stall, 1);
    set_alu(1, 5, 32'hDEADBEEF);
    cycle();
    check_eq("raw_stall_1", obs_stall, 1);
    check_eq("raw_alu_gnt", obs_alu_rdy, 1);
    set_alu(0, 0, '0);
    check_eq("raw_enc", rb.enc, 1);
    check_eq("raw_addrc", rb.addrc, 5);
    cycle();
    check_eq("raw_stall_enc_cycle", obs_stall, 1);
    cycle();
    check_eq("raw_accept", obs_stall, 0);
    check_eq("raw_read", bank_mem[5], 32'hDEADBEEF);
    set_idle();

    // Contention: ALU writes 1,3,5 and MEM writes 2,4
    for (int r = 1; r <= 5; r++) begin
      set_issue(1, 0, 0, r);
      cycle();
    end
    set_idle();
    set_alu(1, 1, 32'hA0000001);
    set_mem(1, 2, 32'hB0000002);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_eq("cont_alu_gnt", obs_alu_rdy, (k % 2 == 0));
      check_eq("cont_enc", rb.enc, 1);
      if (k == 0) set_alu(1, 3, 32'hA0000003);
      if (k == 1) set_mem(1, 4, 32'hB0000004);
      if (k == 2) set_alu(1, 5, 32'hA0000005);
      if (k == 3) set_mem(0, 0, '0);
    end
    cycle();
    set_idle();
    cycle();
    check_eq("cont_busy_clear", rb.busy_vec, 0);

    // r0 writeback and sticky error
    set_mem(1, 0, 32'h12345678);
    cycle();
    check_eq("r0_mem_ready", obs_mem_rdy, 1);
    check_eq("r0_enc", rb.enc, 0);
    set_mem(0, 0, '0);
    set_alu(1, 7, 32'h77777777);
    cycle();
    set_alu(0, 0, '0);
    check_eq("err_enc", rb.enc, 1);
    check_eq("err_addrc", rb.addrc, 7);
    check_eq("err_set", rb.sb_error, 1);
    repeat (3) cycle();
    check_eq("err_sticky", rb.sb_error, 1);

    // WAW and rd = 0
    set_issue(1, 0, 0, 9);
    cycle();
    cycle();
    check_eq("waw_stall_0", obs_stall, 1);
    set_alu(1, 9, 32'h99999999);
    cycle();
    check_eq("waw_stall_1", obs_stall, 1);
    set_alu(0, 0, '0);
    cycle();
    check_eq("waw_stall_enc_cycle", obs_stall, 1);
    cycle();
    check_eq("waw_accept", obs_stall, 0);
    set_issue(1, 0, 0, 0);
    cycle();
    check_eq("rd0_no_stall", obs_stall, 0);
    check_eq("rd0_busy0", rb.busy_vec[0], 0);
    set_issue(0, 0, 0, 0);
    set_alu(1, 9, 32'h99990000);
    cycle();
    set_alu(0, 0, '0);
    cycle();

    // Mid-run reset with busy_vec = 0x6 and enc = 1, pointer left at MEM
    set_issue(1, 0, 0, 1);
    cycle();
    set_issue(1, 0, 0, 2);
    cycle();
    set_idle();
    set_alu(1, 8, 32'h88888888);
    set_mem(1, 10, 32'hAAAAAAAA);
    cycle();
    set_idle();
    check_eq("mrst_pre_enc", rb.enc, 1);
    check_eq("mrst_pre_busy", rb.busy_vec, 32'h6);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_regs("mrst");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    set_alu(1, 11, 32'h11111111);
    set_mem(1, 12, 32'h12121212);
    cycle();
    check_eq("mrst_rr_alu", obs_alu_rdy, 1);
    set_idle();
    cycle();

    // Constrained-random traffic
    model_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    for (int n = 0; n < 600; n++) begin
      set_issue($urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7));
      if (!rb.alu_valid || alu_gnt_q) begin
        new_req(v, a);
        set_alu(v, a, $urandom);
      end
      if (!rb.mem_valid || mem_gnt_q) begin
        new_req(v, a);
        set_mem(v, a, $urandom);
      end
      cycle();
    end
    set_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
